// File: rtl/fifo_readout_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : fifo_readout_gearbox
// Function : Reads 36-bit FIFO words and repacks them into framed 32-bit beats.
// Revision : 1.0 - initial release
// ============================================================================

module fifo_readout_gearbox #(
    parameter int          FRAME_WORDS = 8,
    parameter logic [15:0] HEADER_TAG  = 16'hA5C3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [35:0] fifo_dout,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int c_DATA_BEATS = FRAME_WORDS * 9 / 8;
    localparam int c_WR_W       = $clog2(FRAME_WORDS + 1);
    localparam int c_BT_W       = $clog2(c_DATA_BEATS + 1);
    localparam int c_BUF_W      = 68;

    localparam logic [c_WR_W-1:0] c_WORDS_MAX = c_WR_W'(FRAME_WORDS);
    localparam logic [c_BT_W-1:0] c_LAST_BEAT = c_BT_W'(c_DATA_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PACK   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_BUF_W-1:0]   r_buf;
    logic [c_BUF_W-1:0]   w_buf_nxt;
    logic [c_BUF_W-1:0]   w_shifted;
    logic [6:0]           r_cnt;
    logic [6:0]           w_cnt_nxt;
    logic [6:0]           w_base;
    logic [c_WR_W-1:0]    r_words_read;
    logic [c_BT_W-1:0]    r_beats;
    logic                 r_rd_pend;
    logic [15:0]          r_frame_cnt;
    logic                 w_xfer;

    assign frame_cnt = r_frame_cnt;
    assign busy      = (r_state != IDLE);
    assign w_xfer    = (r_state == PACK) && out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fifo_rd_en  = 1'b0;
        out_valid   = 1'b0;
        out_data    = 32'h0;
        out_last    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    w_state_nxt = HEADER;
                end
            end
            HEADER: begin
                out_valid = 1'b1;
                out_data  = {HEADER_TAG, r_frame_cnt};
                if (out_ready) begin
                    w_state_nxt = PACK;
                end
            end
            PACK: begin
                out_valid  = (r_cnt >= 7'd32);
                out_data   = r_buf[31:0];
                out_last   = (r_cnt >= 7'd32) && (r_beats == c_LAST_BEAT);
                // One read in flight at a time and only while a whole word still fits.
                fifo_rd_en = !fifo_empty && (r_words_read < c_WORDS_MAX) &&
                             !r_rd_pend && (r_cnt <= 7'd31);
                if (out_last && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Arriving data lands above whatever survives this cycle's 32-bit drain.
    always_comb begin
        w_shifted = w_xfer ? (r_buf >> 32) : r_buf;
        w_base    = w_xfer ? (r_cnt - 7'd32) : r_cnt;
        w_buf_nxt = w_shifted;
        w_cnt_nxt = w_base;
        if (r_rd_pend) begin
            w_buf_nxt = w_shifted | ({32'd0, fifo_dout} << w_base);
            w_cnt_nxt = w_base + 7'd36;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf        <= '0;
            r_cnt        <= 7'd0;
            r_words_read <= '0;
            r_beats      <= '0;
            r_rd_pend    <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_rd_pend <= fifo_rd_en;
            if (r_state == PACK) begin
                r_buf <= w_buf_nxt;
                r_cnt <= w_cnt_nxt;
                if (fifo_rd_en) begin
                    r_words_read <= r_words_read + 1'b1;
                end
                if (w_xfer) begin
                    r_beats <= r_beats + 1'b1;
                end
            end else begin
                r_buf        <= '0;
                r_cnt        <= 7'd0;
                r_words_read <= '0;
                r_beats      <= '0;
            end
            if (w_xfer && out_last) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire
